// File: rtl/ram_dp_port_arbiter_pkg.sv
// Shared definitions for the dual-port RAM port arbiter.
//   NUM_CLIENTS      : number of requesters sharing each RAM port
//   GNT_NONE/C0/C1   : one-hot grant encodings used on wr_ack/rd_ack
//   prio_t           : round-robin priority pointer (which client wins a tie)
package ram_dp_port_arbiter_pkg;

    localparam int NUM_CLIENTS = 2;

    localparam logic [NUM_CLIENTS-1:0] GNT_NONE = 2'b00;
    localparam logic [NUM_CLIENTS-1:0] GNT_C0   = 2'b01;
    localparam logic [NUM_CLIENTS-1:0] GNT_C1   = 2'b10;

    typedef enum logic {
        PREFER_C0 = 1'b0,
        PREFER_C1 = 1'b1
    } prio_t;

endpackage

// File: rtl/ram_dp_port_arbiter_if.sv
// Bus bundle between two clients, the arbiter and the dual-port RAM.
//   Client write side : wr_req, wr_addr0/1, wr_data0/1 -> wr_ack
//   Client read side  : rd_req, rd_addr0/1 -> rd_ack, rd_valid, rd_data
//   RAM side          : ram_we, ram_addr_wr, ram_data_wr, ram_addr_rd <- ram_data_rd
// Modports:
//   master : clients plus RAM (drive requests and ram_data_rd)
//   slave  : the arbiter
interface ram_dp_port_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4
);
    import ram_dp_port_arbiter_pkg::*;

    logic [NUM_CLIENTS-1:0] wr_req;
    logic [DEPTH_LOG-1:0]   wr_addr0;
    logic [DEPTH_LOG-1:0]   wr_addr1;
    logic [WIDTH-1:0]       wr_data0;
    logic [WIDTH-1:0]       wr_data1;
    logic [NUM_CLIENTS-1:0] wr_ack;

    logic [NUM_CLIENTS-1:0] rd_req;
    logic [DEPTH_LOG-1:0]   rd_addr0;
    logic [DEPTH_LOG-1:0]   rd_addr1;
    logic [NUM_CLIENTS-1:0] rd_ack;
    logic [NUM_CLIENTS-1:0] rd_valid;
    logic [WIDTH-1:0]       rd_data;

    logic                   ram_we;
    logic [DEPTH_LOG-1:0]   ram_addr_wr;
    logic [WIDTH-1:0]       ram_data_wr;
    logic [DEPTH_LOG-1:0]   ram_addr_rd;
    logic [WIDTH-1:0]       ram_data_rd;

    modport master (
        output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_req, rd_addr0, rd_addr1,
        output ram_data_rd,
        input  wr_ack, rd_ack, rd_valid, rd_data,
        input  ram_we, ram_addr_wr, ram_data_wr, ram_addr_rd
    );

    modport slave (
        input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_req, rd_addr0, rd_addr1,
        input  ram_data_rd,
        output wr_ack, rd_ack, rd_valid, rd_data,
        output ram_we, ram_addr_wr, ram_data_wr, ram_addr_rd
    );

endinterface

// File: rtl/ram_dp_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; also forces gnt to zero
//   req : request per client
//   gnt : one-hot grant, combinational from req and the pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import ram_dp_port_arbiter_pkg::*;

    prio_t ptr;

    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            case (req)
                2'b01:   gnt = GNT_C0;
                2'b10:   gnt = GNT_C1;
                2'b11:   gnt = (ptr == PREFER_C1) ? GNT_C1 : GNT_C0;
                default: gnt = GNT_NONE;
            endcase
        end
    end

    // The client just served loses the next tie; no grant leaves the pointer alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PREFER_C0;
        end else if (gnt == GNT_C0) begin
            ptr <= PREFER_C1;
        end else if (gnt == GNT_C1) begin
            ptr <= PREFER_C0;
        end
    end

endmodule

// File: rtl/ram_dp_port_arbiter.sv
// Shares the write port and the asynchronous read port of a dual-port RAM
// between two clients. Each port has its own round-robin arbiter, so one
// write and one read can be granted in the same cycle. Read data is captured
// on the granted edge and returned with a per-client rd_valid pulse.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : client request/ack signals and RAM port signals (slave modport)
module ram_dp_port_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_dp_port_arbiter_if.slave  bus
);
    import ram_dp_port_arbiter_pkg::*;

    logic [NUM_CLIENTS-1:0] wr_gnt;
    logic [NUM_CLIENTS-1:0] rd_gnt;
    logic [NUM_CLIENTS-1:0] rd_valid_q;
    logic [WIDTH-1:0]       rd_data_q;
    logic [WIDTH-1:0]       wr_data_mux;
    logic [DEPTH_LOG-1:0]   wr_addr_mux;
    logic [DEPTH_LOG-1:0]   rd_addr_mux;

    rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.wr_req),
        .gnt (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.rd_req),
        .gnt (rd_gnt)
    );

    // Ungranted (and in-reset) cycles drive zeros onto the RAM address/data.
    always_comb begin
        wr_addr_mux = '0;
        wr_data_mux = '0;
        case (wr_gnt)
            GNT_C0: begin
                wr_addr_mux = bus.wr_addr0;
                wr_data_mux = bus.wr_data0;
            end
            GNT_C1: begin
                wr_addr_mux = bus.wr_addr1;
                wr_data_mux = bus.wr_data1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_addr_mux = '0;
        case (rd_gnt)
            GNT_C0:  rd_addr_mux = bus.rd_addr0;
            GNT_C1:  rd_addr_mux = bus.rd_addr1;
            default: ;
        endcase
    end

    // Capturing at the granted edge reads the RAM before any same-edge write
    // lands, so a colliding read sees the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= GNT_NONE;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_gnt;
            if (|rd_gnt) begin
                rd_data_q <= bus.ram_data_rd;
            end
        end
    end

    assign bus.wr_ack      = wr_gnt;
    assign bus.rd_ack      = rd_gnt;
    assign bus.ram_we      = |wr_gnt;
    assign bus.ram_addr_wr = wr_addr_mux;
    assign bus.ram_data_wr = wr_data_mux;
    assign bus.ram_addr_rd = rd_addr_mux;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_ram_dp_port_arbiter.sv
// Scoreboard bench for ram_dp_port_arbiter: job queues per client and port,
// a reference model of arbitration and memory contents, a RAM model, and a
// monitor that checks each returned read against the expected queue.
module tb_ram_dp_port_arbiter;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } job_t;

    typedef struct packed {
        logic [1:0] c;
        logic [7:0] d;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    ram_dp_port_arbiter_if #(.WIDTH(8), .DEPTH_LOG(4)) bus ();

    ram_dp_port_arbiter #(.WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM fixture: synchronous write, asynchronous read
    logic [7:0] ram [16] = '{default: 8'h00};
    always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr_wr] <= bus.ram_data_wr;
    assign bus.ram_data_rd = ram[bus.ram_addr_rd];

    // Reference model state
    logic [7:0] mm [16] = '{default: 8'h00};
    int         wr_pref = 0;
    int         rd_pref = 0;
    logic [1:0] wr_acked = 2'b00;
    logic [1:0] rd_acked = 2'b00;
    rd_exp_t    sb [$];
    logic [7:0] last_data = 8'h00;

    job_t wq0 [$];
    job_t wq1 [$];
    job_t rq0 [$];
    job_t rq1 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lone requester wins; a tie goes to the preferred client.
    function automatic logic [1:0] pick(input logic [1:0] req, input int pref);
        if (req == 2'b11) return (pref == 0) ? 2'b01 : 2'b10;
        return req;
    endfunction

    // Driver: present the head job of each queue, retire it once acked.
    initial begin
        bus.wr_req = '0; bus.rd_req = '0;
        bus.wr_addr0 = '0; bus.wr_addr1 = '0; bus.wr_data0 = '0; bus.wr_data1 = '0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0;
        forever begin
            @(posedge clk); #1;
            if (wr_acked[0] && wq0.size() != 0) void'(wq0.pop_front());
            if (wr_acked[1] && wq1.size() != 0) void'(wq1.pop_front());
            if (rd_acked[0] && rq0.size() != 0) void'(rq0.pop_front());
            if (rd_acked[1] && rq1.size() != 0) void'(rq1.pop_front());
            bus.wr_req = {wq1.size() != 0, wq0.size() != 0};
            bus.rd_req = {rq1.size() != 0, rq0.size() != 0};
            if (wq0.size() != 0) begin bus.wr_addr0 = wq0[0].a; bus.wr_data0 = wq0[0].d; end
            if (wq1.size() != 0) begin bus.wr_addr1 = wq1[0].a; bus.wr_data1 = wq1[0].d; end
            if (rq0.size() != 0) bus.rd_addr0 = rq0[0].a;
            if (rq1.size() != 0) bus.rd_addr1 = rq1[0].a;
        end
    end

    // Grant checker: compares acks and RAM-side outputs, pushes expected reads.
    initial forever begin
        logic [1:0] ew, er;
        logic [3:0] ewa, era;
        logic [7:0] ewd;
        @(negedge clk);
        if (rst) begin
            ew = 2'b00; er = 2'b00; wr_pref = 0; rd_pref = 0;
        end else begin
            ew = pick(bus.wr_req, wr_pref);
            er = pick(bus.rd_req, rd_pref);
        end
        ewa = (ew == 2'b01) ? bus.wr_addr0 : (ew == 2'b10) ? bus.wr_addr1 : 4'd0;
        ewd = (ew == 2'b01) ? bus.wr_data0 : (ew == 2'b10) ? bus.wr_data1 : 8'd0;
        era = (er == 2'b01) ? bus.rd_addr0 : (er == 2'b10) ? bus.rd_addr1 : 4'd0;
        chk("wr_ack", 32'(bus.wr_ack), 32'(ew));
        chk("rd_ack", 32'(bus.rd_ack), 32'(er));
        chk("ram_we", 32'(bus.ram_we), 32'(ew != 2'b00));
        chk("ram_addr_wr", 32'(bus.ram_addr_wr), 32'(ewa));
        chk("ram_data_wr", 32'(bus.ram_data_wr), 32'(ewd));
        chk("ram_addr_rd", 32'(bus.ram_addr_rd), 32'(era));
        if (er != 2'b00) sb.push_back('{c: er, d: mm[era]});
        if (ew != 2'b00) mm[ewa] = ewd;
        if (ew != 2'b00) wr_pref = (ew == 2'b01) ? 1 : 0;
        if (er != 2'b00) rd_pref = (er == 2'b01) ? 1 : 0;
        wr_acked = ew;
        rd_acked = er;
    end

    // Monitor: checks rd_valid/rd_data one cycle after each read grant.
    initial forever begin
        rd_exp_t e;
        @(posedge clk); #2;
        if (rst) begin
            sb.delete();
            last_data = 8'h00;
            chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
            chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            last_data = e.d;
            chk("rd_valid", 32'(bus.rd_valid), 32'(e.c));
            chk("rd_data", 32'(bus.rd_data), 32'(e.d));
        end else begin
            chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
            chk("hold_rd_data", 32'(bus.rd_data), 32'(last_data));
        end
    end

    task automatic run_idle();
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk); #3;
            if (wq0.size() == 0 && wq1.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
                bus.wr_req == 2'b00 && bus.rd_req == 2'b00) done = 1;
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic wait_valid(output logic [1:0] v, output logic [7:0] d);
        bit got = 0;
        v = 2'b00; d = 8'h00;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #2;
            if (bus.rd_valid != 2'b00) begin
                v = bus.rd_valid; d = bus.rd_data; got = 1;
            end
        end
        if (!got) chk("rd_valid_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [1:0] v;
        logic [7:0] d;
        logic [1:0] seq [4];
        logic [1:0] seq_exp [4];
        seq_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;

        // Reset mid-operation with both clients requesting on both ports
        for (int i = 0; i < 4; i++) begin
            wq0.push_back('{a: 4'(i), d: 8'(8'h40 + i)});
            wq1.push_back('{a: 4'(i + 8), d: 8'(8'h80 + i)});
            rq0.push_back('{a: 4'(i), d: 8'h00});
            rq1.push_back('{a: 4'(i + 8), d: 8'h00});
        end
        @(posedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
        chk("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_now_rd_valid", 32'(bus.rd_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_first", 32'(bus.wr_ack), 32'(2'b01));
        chk("post_rst_rd_first", 32'(bus.rd_ack), 32'(2'b01));
        run_idle();

        // Single client write then read
        wq1.push_back('{a: 4'd3, d: 8'hA5});
        run_idle();
        rq1.push_back('{a: 4'd3, d: 8'h00});
        wait_valid(v, d);
        chk("single_valid", 32'(v), 32'(2'b10));
        chk("single_data", 32'(d), 32'h0A5);
        run_idle();

        // Write contention: strict alternation starting from client 0
        wq0.push_back('{a: 4'd1, d: 8'h11}); wq0.push_back('{a: 4'd1, d: 8'h11});
        wq1.push_back('{a: 4'd2, d: 8'h22}); wq1.push_back('{a: 4'd2, d: 8'h22});
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = bus.wr_ack;
        end
        for (int i = 0; i < 4; i++) chk("contention_seq", 32'(seq[i]), 32'(seq_exp[i]));
        run_idle();
        rq0.push_back('{a: 4'd1, d: 8'h00});
        rq1.push_back('{a: 4'd2, d: 8'h00});
        for (int i = 0; i < 2; i++) begin
            wait_valid(v, d);
            chk("contention_rd", 32'(d), (v == 2'b01) ? 32'h11 : 32'h22);
        end
        run_idle();

        // Same-cycle write/read of one address returns the old word
        wq0.push_back('{a: 4'd5, d: 8'h0F});
        run_idle();
        wq0.push_back('{a: 4'd5, d: 8'hF0});
        rq1.push_back('{a: 4'd5, d: 8'h00});
        rq1.push_back('{a: 4'd5, d: 8'h00});
        wait_valid(v, d);
        chk("hazard_old", 32'(d), 32'h0F);
        wait_valid(v, d);
        chk("hazard_new", 32'(d), 32'hF0);
        run_idle();

        // Independent ports over every address, then a wrapping sweep
        for (int i = 0; i < 16; i++) begin
            wq0.push_back('{a: 4'(i), d: 8'($urandom)});
            rq1.push_back('{a: 4'(i), d: 8'h00});
        end
        run_idle();
        for (int i = 0; i < 16; i++) rq0.push_back('{a: 4'((i + 8) % 16), d: 8'h00});
        run_idle();

        // Idle: monitor checks rd_data holds and rd_valid stays low
        repeat (10) @(posedge clk);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #3;
            if ($urandom_range(0, 2) == 0 && wq0.size() < 3)
                wq0.push_back('{a: 4'($urandom_range(0, 15)), d: 8'($urandom)});
            if ($urandom_range(0, 2) == 0 && wq1.size() < 3)
                wq1.push_back('{a: 4'($urandom_range(0, 15)), d: 8'($urandom)});
            if ($urandom_range(0, 2) == 0 && rq0.size() < 3)
                rq0.push_back('{a: 4'($urandom_range(0, 15)), d: 8'h00});
            if ($urandom_range(0, 2) == 0 && rq1.size() < 3)
                rq1.push_back('{a: 4'($urandom_range(0, 15)), d: 8'h00});
        end
        run_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
